// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: d = a - b, LSB first, one bit per clock.
// A start/busy/done handshake frames each operation; the difference and
// borrow-out are registered and held until the next completed operation.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bo
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             accept;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic [WIDTH-1:0] res;
  logic             borrow;
  logic [CW-1:0]    count;
  logic             diff;
  logic             borrow_nxt;

  // One-bit full-subtractor difference.
  function automatic logic diff_bit(input logic x, input logic y, input logic bin);
    return x ^ y ^ bin;
  endfunction

  // One-bit full-subtractor borrow: borrow when x < y + bin.
  function automatic logic borrow_bit(input logic x, input logic y, input logic bin);
    return (~x & y) | (~(x ^ y) & bin);
  endfunction

  // State register; reset returns to IDLE and aborts any operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake decode; start is only honoured in IDLE or DONE.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (count == LAST) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          accept    = 1'b1;
          state_nxt = SHIFT;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Current bit slice of the serial subtraction.
  always_comb begin
    diff       = diff_bit(ra[0], rb[0], borrow);
    borrow_nxt = borrow_bit(ra[0], rb[0], borrow);
  end

  // Operand capture, bit-serial shifting, and result publication on the last bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      ra     <= '0;
      rb     <= '0;
      res    <= '0;
      borrow <= 1'b0;
      count  <= '0;
      d      <= '0;
      bo     <= 1'b0;
    end else if (accept) begin
      ra     <= a;
      rb     <= b;
      borrow <= 1'b0;
      count  <= '0;
    end else if (state == SHIFT) begin
      res    <= {diff, res[WIDTH-1:1]};
      ra     <= ra >> 1;
      rb     <= rb >> 1;
      borrow <= borrow_nxt;
      if (count == LAST) begin
        // Final bit: publish the full difference and borrow for the DONE cycle.
        d  <= {diff, res[WIDTH-1:1]};
        bo <= borrow_nxt;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Testbench for serial_subtractor: a WIDTH=4 and a WIDTH=8 instance share the
// clock and reset; a select bit routes the common stimulus to one of them.
module tb_serial_subtractor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start_t;
  logic       sel;
  logic [7:0] a_t;
  logic [7:0] b_t;
  logic       start4;
  logic       start8;

  logic       busy4, done4, bo4;
  logic [3:0] d4;
  logic       busy8, done8, bo8;
  logic [7:0] d8;

  logic       busy_o, done_o, bo_o;
  logic [7:0] d_o;

  int total = 0;
  int bad   = 0;

  assign start4 = start_t & ~sel;
  assign start8 = start_t & sel;

  serial_subtractor #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst), .start(start4), .a(a_t[3:0]), .b(b_t[3:0]),
    .busy(busy4), .done(done4), .d(d4), .bo(bo4)
  );

  serial_subtractor #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(start8), .a(a_t), .b(b_t),
    .busy(busy8), .done(done8), .d(d8), .bo(bo8)
  );

  always_comb begin
    busy_o = sel ? busy8 : busy4;
    done_o = sel ? done8 : done4;
    bo_o   = sel ? bo8   : bo4;
    d_o    = sel ? d8    : {4'b0000, d4};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", tag, got, exp);
    end
  endtask

  // Reference: plain integer subtraction, returns {borrow, difference mod 2^width}.
  function automatic logic [8:0] ref_sub(input int av, input int bv, input int width);
    int modv;
    int dm;
    modv = 1 << width;
    dm   = (av - bv + modv) % modv;
    return {(av < bv), 8'(dm)};
  endfunction

  // One operation with a one-cycle start pulse; optionally raises start again
  // (with other operands) during the second busy cycle, which must be ignored.
  task automatic single_op(input int av, input int bv, input bit intrude, input string tag);
    int         w;
    int         n;
    bit         seen;
    logic [8:0] e;
    w = sel ? 8 : 4;
    e = ref_sub(av, bv, w);
    @(negedge clk);
    a_t = 8'(av);
    b_t = 8'(bv);
    start_t = 1'b1;
    n = 0;
    seen = 1'b0;
    while (!seen && n <= w + 3) begin
      @(negedge clk);
      n++;
      if (done_o) begin
        seen = 1'b1;
        check({tag, " latency"}, n, w + 1);
        check({tag, " d"}, d_o, e[7:0]);
        check({tag, " bo"}, bo_o, e[8]);
        check({tag, " busy@done"}, busy_o, 0);
      end else begin
        check({tag, " busy"}, busy_o, 1);
      end
      if (n == 1) start_t = 1'b0;
      if (intrude && n == 2) begin
        start_t = 1'b1;
        a_t = 8'd0;
        b_t = 8'd9;
      end
      if (intrude && n == 3) start_t = 1'b0;
    end
    check({tag, " done seen"}, seen, 1);
    start_t = 1'b0;
    @(negedge clk);
    check({tag, " done pulse"}, done_o, 0);
    check({tag, " idle busy"}, busy_o, 0);
  endtask

  // Back-to-back operations with start held high; new operands are presented
  // during each DONE cycle, so every DONE must chain straight into SHIFT.
  task automatic chain(input int nops, input string tag);
    int         w;
    int         mask;
    int         n;
    int         cnt;
    int         av;
    int         bv;
    logic [8:0] e;
    w = sel ? 8 : 4;
    mask = (1 << w) - 1;
    av = int'($urandom_range(32'(mask), 0));
    bv = int'($urandom_range(32'(mask), 0));
    e = ref_sub(av, bv, w);
    @(negedge clk);
    a_t = 8'(av);
    b_t = 8'(bv);
    start_t = 1'b1;
    n = 0;
    cnt = 0;
    while (cnt < nops) begin
      @(negedge clk);
      n++;
      if (done_o) begin
        check({tag, " latency"}, n, w + 1);
        check({tag, " d"}, d_o, e[7:0]);
        check({tag, " bo"}, bo_o, e[8]);
        check({tag, " busy@done"}, busy_o, 0);
        cnt++;
        n = 0;
        if (cnt < nops) begin
          av = int'($urandom_range(32'(mask), 0));
          bv = int'($urandom_range(32'(mask), 0));
          e = ref_sub(av, bv, w);
          a_t = 8'(av);
          b_t = 8'(bv);
        end else begin
          start_t = 1'b0;
        end
      end else begin
        check({tag, " busy"}, busy_o, 1);
        if (n > w + 2) begin
          check({tag, " timeout"}, 0, 1);
          start_t = 1'b0;
          break;
        end
      end
    end
    @(negedge clk);
    check({tag, " end idle busy"}, busy_o, 0);
    check({tag, " end idle done"}, done_o, 0);
  endtask

  // Reset asserted during the second busy cycle must abort with no done pulse.
  task automatic reset_mid();
    @(negedge clk);
    a_t = 8'd12;
    b_t = 8'd7;
    start_t = 1'b1;
    @(negedge clk);
    start_t = 1'b0;
    check("rst busy1", busy_o, 1);
    @(negedge clk);
    check("rst busy2", busy_o, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst busy", busy_o, 0);
    check("rst done", done_o, 0);
    check("rst d", d_o, 0);
    check("rst bo", bo_o, 0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("rst no done", done_o, 0);
    end
  endtask

  initial begin
    rst = 1'b1;
    start_t = 1'b0;
    sel = 1'b0;
    a_t = 8'd0;
    b_t = 8'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset busy4", busy4, 0);
    check("reset done4", done4, 0);
    check("reset d4", d4, 0);
    check("reset bo4", bo4, 0);
    check("reset busy8", busy8, 0);
    check("reset done8", done8, 0);
    check("reset d8", d8, 0);
    check("reset bo8", bo8, 0);

    sel = 1'b0;
    single_op(10, 3, 1'b0, "w4 10-3");
    single_op(3, 10, 1'b0, "w4 3-10");
    single_op(0, 0, 1'b0, "w4 0-0");
    single_op(15, 15, 1'b0, "w4 15-15");
    single_op(5, 1, 1'b1, "w4 ignore");
    single_op(0, 15, 1'b0, "w4 0-15");
    single_op(15, 0, 1'b0, "w4 15-0");
    chain(12, "w4 chain");
    chain(200, "w4 rand");
    single_op(10, 3, 1'b0, "w4 pre-rst");
    reset_mid();
    single_op(9, 4, 1'b0, "w4 post-rst");

    sel = 1'b1;
    single_op(0, 255, 1'b0, "w8 0-255");
    single_op(255, 0, 1'b0, "w8 255-0");
    single_op(128, 127, 1'b0, "w8 128-127");
    single_op(127, 128, 1'b0, "w8 127-128");
    single_op(255, 255, 1'b0, "w8 255-255");
    single_op(0, 0, 1'b0, "w8 0-0");
    chain(2500, "w8 rand");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
